// File: rtl/sarmux_scan.sv
// sarmux_scan - round-robin SAR scan controller for a shared DAC/comparator.
//
// Converts the enabled analog channels in ascending index order. Each
// channel gets a sample phase followed by a successive-approximation search
// at full (NBIT) or reduced (NBIT-2) resolution, then a one-cycle store that
// strobes the result to the register bank and updates the sticky window
// alerts. Rounds run once or repeat continuously.
//
// Ports:
//   clk, srst          system clock, synchronous active-high reset
//   start, stop        begin a round when idle / finish at the next channel boundary
//   cont               restart a new round automatically after the last channel
//   hires              full resolution when 1, two LSBs forced to 0 when 0
//   ch_en              channel enable mask (sampled live for next-channel search)
//   win_en             enables the thr_lo..thr_hi window check
//   thr_lo, thr_hi     inclusive window limits
//   alert_clr          write-1-to-clear for the alert flags
//   comp_i             comparator, 1 = analog input above the DAC code
//   dac_o, dac_en_o    DAC code and DAC/comparator power enable
//   ch_sel_o           analog mux select
//   sample_o           sampler switch closed
//   res_wr/res_ch/res_dat  one-cycle result strobe, channel and code
//   busy, done         scan in progress / one-cycle end-of-round pulse
//   alert              sticky out-of-window flags, one per channel
module sarmux_scan #(
    parameter int NCH      = 16,
    parameter int NBIT     = 10,
    parameter int SMPL_CYC = 4,
    parameter int SETL_CYC = 2,
    parameter int CW       = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            start,
    input  logic            stop,
    input  logic            cont,
    input  logic            hires,
    input  logic [NCH-1:0]  ch_en,
    input  logic            win_en,
    input  logic [NBIT-1:0] thr_lo,
    input  logic [NBIT-1:0] thr_hi,
    input  logic [NCH-1:0]  alert_clr,
    input  logic            comp_i,
    output logic [NBIT-1:0] dac_o,
    output logic            dac_en_o,
    output logic [CW-1:0]   ch_sel_o,
    output logic            sample_o,
    output logic            res_wr,
    output logic [CW-1:0]   res_ch,
    output logic [NBIT-1:0] res_dat,
    output logic            busy,
    output logic            done,
    output logic [NCH-1:0]  alert
);

    localparam int CMAX = (SMPL_CYC > SETL_CYC) ? SMPL_CYC : SETL_CYC;
    localparam int CNTW = $clog2(CMAX + 1);
    localparam logic [NBIT-1:0] MSB_BIT = {1'b1, {(NBIT-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SAMP, CONV, STOR} state_t;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [NBIT-1:0] acc;
    logic [NBIT-1:0] bitm;
    logic            hires_l;
    logic            stop_pend;
    logic            round_end;
    logic [CW-1:0]   next_l;

    logic [CW-1:0]   low_ch;
    logic [CW-1:0]   next_ch;
    logic            next_found;
    logic [NBIT-1:0] lsb_mask;
    logic [NBIT-1:0] new_acc;
    logic            end_now;
    logic            win_out;
    logic [NCH-1:0]  alert_set;

    // The DAC and comparator are only powered while a scan is running.
    assign dac_en_o = busy;

    // Lowest enabled channel (round start) and lowest enabled channel above
    // the current one (round continuation). Scanning downwards lets the last
    // hit be the lowest index.
    always_comb begin
        low_ch     = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_en[i]) begin
                low_ch = CW'(i);
                if (i > int'(ch_sel_o)) begin
                    next_ch    = CW'(i);
                    next_found = 1'b1;
                end
            end
        end
    end

    // Datapath helpers: the trial bit mask walks down from the MSB and the
    // search ends on bit 0 (full) or bit 2 (reduced). The kept value is the
    // trial code itself when the comparator says the input is above it.
    always_comb begin
        lsb_mask  = hires_l ? NBIT'(1) : NBIT'(4);
        new_acc   = comp_i ? dac_o : acc;
        end_now   = !next_found || stop_pend || stop;
        win_out   = win_en && ((res_dat < thr_lo) || (res_dat > thr_hi));
        alert_set = (state == STOR && win_out) ? (NCH'(1) << res_ch) : '0;
    end

    // Main controller. All outputs are registered here so the analog side
    // sees glitch-free controls. The result, done and next-channel decision
    // are all taken on the CONV->STOR edge so that done can be a register
    // that is already valid during the STOR cycle. A set alert wins over a
    // simultaneous clear so an event is never lost.
    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            bitm      <= '0;
            hires_l   <= 1'b0;
            stop_pend <= 1'b0;
            round_end <= 1'b0;
            next_l    <= '0;
            dac_o     <= '0;
            ch_sel_o  <= '0;
            sample_o  <= 1'b0;
            res_wr    <= 1'b0;
            res_ch    <= '0;
            res_dat   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            alert     <= '0;
        end else begin
            alert <= (alert & ~alert_clr) | alert_set;
            if (stop && state != IDLE) begin
                stop_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start && (|ch_en) && !stop) begin
                        state    <= SAMP;
                        ch_sel_o <= low_ch;
                        hires_l  <= hires;
                        cnt      <= '0;
                        sample_o <= 1'b1;
                        dac_o    <= '0;
                        busy     <= 1'b1;
                    end
                end
                SAMP: begin
                    if (cnt == CNTW'(SMPL_CYC - 1)) begin
                        state    <= CONV;
                        sample_o <= 1'b0;
                        cnt      <= '0;
                        acc      <= '0;
                        bitm     <= MSB_BIT;
                        dac_o    <= MSB_BIT;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                CONV: begin
                    if (cnt == CNTW'(SETL_CYC - 1)) begin
                        cnt <= '0;
                        acc <= new_acc;
                        if (bitm == lsb_mask) begin
                            state     <= STOR;
                            dac_o     <= '0;
                            res_wr    <= 1'b1;
                            res_dat   <= new_acc;
                            res_ch    <= ch_sel_o;
                            done      <= end_now;
                            round_end <= end_now;
                            next_l    <= next_ch;
                        end else begin
                            bitm  <= bitm >> 1;
                            dac_o <= new_acc | (bitm >> 1);
                        end
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                STOR: begin
                    res_wr <= 1'b0;
                    done   <= 1'b0;
                    if (round_end) begin
                        if (cont && !stop_pend && !stop && (|ch_en)) begin
                            state    <= SAMP;
                            ch_sel_o <= low_ch;
                            hires_l  <= hires;
                            cnt      <= '0;
                            sample_o <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end
                    end else begin
                        state    <= SAMP;
                        ch_sel_o <= next_l;
                        hires_l  <= hires;
                        cnt      <= '0;
                        sample_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
